rom_scanner: RTL and testbench
==============================

# rom_scanner

Sequential read controller for the 8×4 combinational lookup ROM (3-bit address, 4-bit data). On a start request it walks a contiguous, wrap-around window of 1–8 ROM words, emitting each word with a valid strobe and accumulating a running sum and maximum. It sits between the board-level control (switches/buttons) and the ROM, replacing manual address stepping.

## Interface
Parameters: none. ROM geometry is fixed at 8 words × 4 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  start request; sampled only in IDLE
- start_addr  input  3  first ROM address to read
- len_m1  input  3  window length minus one (0 → 1 word, 7 → 8 words)
- ROM_addr  output  3  address driven to the ROM (registered)
- ROM_data  input  4  combinational data returned by the ROM for ROM_addr
- data_out  output  4  last captured ROM word
- data_valid  output  1  one-cycle strobe, data_out holds a new word
- sum  output  7  sum of all words in the current/last window
- max_val  output  4  largest word in the current/last window
- busy  output  1  high while in FETCH
- done  output  1  one-cycle pulse when the window completes

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: busy=0. On start=1: ROM_addr←start_addr, remaining←len_m1, sum←0, max_val←0, go to FETCH.
- FETCH (one word per cycle): data_out←ROM_data, data_valid←1, sum←sum+ROM_data, max_val←max(max_val, ROM_data), ROM_addr←ROM_addr+1 (mod 8, 7 wraps to 0). If remaining==0 → DONE, else remaining←remaining−1, stay.
- DONE: done=1 for exactly one cycle, then IDLE. start ignored in DONE.
- start while busy or in DONE is ignored; window parameters are captured only at the IDLE start edge.
- Arithmetic: sum is 7-bit unsigned; maximum 8×15=120, never overflows. max_val comparison unsigned; ties keep the value.
- sum, max_val, data_out hold their values in IDLE/DONE until the next accepted start.
- Reset (asynchronous, any state including mid-window): state←IDLE; ROM_addr=0, data_out=0, data_valid=0, sum=0, max_val=0, busy=0, done=0, remaining=0.

## Timing
- start sampled high in IDLE at edge E0 → FETCH from E0; ROM_addr=start_addr during the cycle after E0.
- ROM is combinational: ROM_data is used in the same cycle ROM_addr is presented.
- N=len_m1+1 words. Word k (0-based) appears on data_out with data_valid=1 in cycle k+2 after the start edge (first word two cycles after start is sampled, counting the start cycle as 0).
- busy=1 for exactly N cycles (cycles 1..N).
- done=1 in cycle N+1, coincident with the final data_valid; sum and max_val are final in that cycle.
- Earliest next start accepted: cycle N+2 (IDLE). Back-to-back windows: gap of one cycle minimum between windows.
- data_valid is never high for two different windows without an intervening done.

## Test plan
Bench ROM model: word[k]=2k+1 (1,3,5,7,9,11,13,15).
- Reset then idle: assert rst mid-cycle → all outputs 0 immediately (asynchronous), state IDLE; start with rst held → no activity.
- Full window: start_addr=0, len_m1=7 → 8 data_valid strobes with data_out 1,3,…,15; done in cycle 9; sum=64, max_val=15; busy high exactly 8 cycles.
- Wrap-around: start_addr=6, len_m1=3 → words 13,15,1,3 (addresses 6,7,0,1); sum=32, max_val=15.
- Single word: start_addr=2, len_m1=0 → one strobe data_out=5, done in cycle 2, sum=5, max_val=5.
- start ignored while busy: start_addr=0, len_m1=4, pulse start again with start_addr=5 in cycle 2 → words 1,3,5,7,9 only, sum=25; no second window.
- Reset mid-window: start_addr=0, len_m1=7, assert rst in cycle 4 → outputs cleared at once, no done pulse; new start after release runs a fresh window with sum from 0.

Source files
------------

// File: rtl/rom_scanner.sv
// rom_scanner: walks a wrap-around window of 1-8 words of an 8x4 combinational ROM,
// strobing each word out and accumulating the window's sum and maximum.
module rom_scanner (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] start_addr,
    input  logic [2:0] len_m1,
    output logic [2:0] ROM_addr,
    input  logic [3:0] ROM_data,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic [6:0] sum,
    output logic [3:0] max_val,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t     state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [2:0] rem_q, rem_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [6:0] sum_q, sum_d;
    logic [3:0] max_q, max_d;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sum_d   = sum_q;
        max_d   = max_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = FETCH;
                addr_d  = start_addr;
                rem_d   = len_m1;
                sum_d   = 7'd0;
                max_d   = 4'd0;
            end
        end else if (state_q == FETCH) begin
            data_d  = ROM_data;
            valid_d = 1'b1;
            sum_d   = sum_q + {3'd0, ROM_data};
            max_d   = (ROM_data > max_q) ? ROM_data : max_q;
            addr_d  = addr_q + 3'd1;
            state_d = (rem_q == 3'd0) ? DONE : FETCH;
            rem_d   = (rem_q == 3'd0) ? rem_q : rem_q - 3'd1;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 3'd0;
            rem_q   <= 3'd0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
            sum_q   <= 7'd0;
            max_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
        end
    end
    assign ROM_addr   = addr_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign sum        = sum_q;
    assign max_val    = max_q;
    assign busy       = (state_q == FETCH);
    assign done       = (state_q == DONE);
endmodule

// File: tb/tb_rom_scanner.sv
// tb_rom_scanner: directed checks of rom_scanner against a ROM holding word[k]=2k+1.
module tb_rom_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] start_addr = 3'd0;
    logic [2:0] len_m1 = 3'd0;
    logic [2:0] ROM_addr;
    logic [3:0] ROM_data;
    logic [3:0] data_out;
    logic       data_valid;
    logic [6:0] sum;
    logic [3:0] max_val;
    logic       busy;
    logic       done;
    int n_checks = 0;
    int n_fail = 0;
    logic       ob_busy[0:15];
    logic       ob_done[0:15];
    logic       ob_valid[0:15];
    logic [3:0] ob_data[0:15];
    logic [6:0] ob_sum[0:15];
    logic [3:0] ob_max[0:15];
    logic [2:0] ob_addr[0:15];

    rom_scanner dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len_m1(len_m1),
        .ROM_addr(ROM_addr), .ROM_data(ROM_data), .data_out(data_out), .data_valid(data_valid),
        .sum(sum), .max_val(max_val), .busy(busy), .done(done)
    );

    assign ROM_data = {ROM_addr, 1'b1};
    always #5 clk = ~clk;

    // Records outputs at the negedge of cycles 1..ncyc after the start edge; optionally re-pulses start in cycle xc.
    task automatic launch(input logic [2:0] sa, input logic [2:0] lm, input int ncyc, input int xc, input logic [2:0] xa);
        @(negedge clk);
        start = 1'b1;
        start_addr = sa;
        len_m1 = lm;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            ob_busy[c] = busy;
            ob_done[c] = done;
            ob_valid[c] = data_valid;
            ob_data[c] = data_out;
            ob_sum[c] = sum;
            ob_max[c] = max_val;
            ob_addr[c] = ROM_addr;
            start = (c == xc);
            if (c == xc) start_addr = xa;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({ROM_addr, data_out, data_valid, sum, max_val, busy, done} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", {ROM_addr, data_out, data_valid, sum, max_val, busy, done});
        end
        start = 1'b1;
        start_addr = 3'd3;
        len_m1 = 3'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || ROM_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL start_under_reset busy=%b valid=%b addr=%0d want 0,0,0", busy, data_valid, ROM_addr);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_release busy=%b done=%b want 0,0", busy, done);
        end
    endtask

    task automatic test_full;
        int nb;
        logic ev;
        nb = 0;
        launch(3'd0, 3'd7, 11, 0, 3'd0);
        n_checks++;
        if (ob_addr[1] !== 3'd0) begin
            n_fail++;
            $display("FAIL full_first_addr got=%0d want=0", ob_addr[1]);
        end
        for (int c = 1; c <= 11; c++) begin
            nb += ob_busy[c];
            ev = (c >= 2 && c <= 9);
            n_checks++;
            if (ob_valid[c] !== ev || ob_done[c] !== (c == 9) || ob_busy[c] !== (c <= 8)) begin
                n_fail++;
                $display("FAIL full_ctrl c=%0d valid=%b done=%b busy=%b want %b,%b,%b", c, ob_valid[c], ob_done[c], ob_busy[c], ev, c == 9, c <= 8);
            end
            if (ev) begin
                n_checks++;
                if (ob_data[c] !== 4'(2 * (c - 2) + 1) || ob_sum[c] !== 7'((c - 1) * (c - 1))) begin
                    n_fail++;
                    $display("FAIL full_data c=%0d data=%0d sum=%0d want %0d,%0d", c, ob_data[c], ob_sum[c], 2 * (c - 2) + 1, (c - 1) * (c - 1));
                end
            end
        end
        n_checks++;
        if (nb != 8 || ob_sum[9] !== 7'd64 || ob_max[9] !== 4'd15 || ob_sum[11] !== 7'd64 || ob_data[11] !== 4'd15) begin
            n_fail++;
            $display("FAIL full_final busy_cycles=%0d sum=%0d max=%0d held_sum=%0d held_data=%0d want 8,64,15,64,15", nb, ob_sum[9], ob_max[9], ob_sum[11], ob_data[11]);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] ew;
        launch(3'd6, 3'd3, 7, 0, 3'd0);
        for (int c = 2; c <= 5; c++) begin
            ew = 4'(2 * ((6 + c - 2) % 8) + 1);
            n_checks++;
            if (ob_valid[c] !== 1'b1 || ob_data[c] !== ew) begin
                n_fail++;
                $display("FAIL wrap_data c=%0d valid=%b data=%0d want 1,%0d", c, ob_valid[c], ob_data[c], ew);
            end
        end
        n_checks++;
        if (ob_done[5] !== 1'b1 || ob_sum[5] !== 7'd32 || ob_max[5] !== 4'd15 || ob_valid[6] !== 1'b0 || ob_busy[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_final done=%b sum=%0d max=%0d valid6=%b busy5=%b want 1,32,15,0,0", ob_done[5], ob_sum[5], ob_max[5], ob_valid[6], ob_busy[5]);
        end
    endtask

    task automatic test_single;
        launch(3'd2, 3'd0, 4, 0, 3'd0);
        n_checks++;
        if (ob_busy[1] !== 1'b1 || ob_busy[2] !== 1'b0 || ob_valid[1] !== 1'b0 || ob_valid[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ctrl busy1=%b busy2=%b valid1=%b valid3=%b want 1,0,0,0", ob_busy[1], ob_busy[2], ob_valid[1], ob_valid[3]);
        end
        n_checks++;
        if (ob_valid[2] !== 1'b1 || ob_done[2] !== 1'b1 || ob_data[2] !== 4'd5 || ob_sum[2] !== 7'd5 || ob_max[2] !== 4'd5) begin
            n_fail++;
            $display("FAIL single_word valid=%b done=%b data=%0d sum=%0d max=%0d want 1,1,5,5,5", ob_valid[2], ob_done[2], ob_data[2], ob_sum[2], ob_max[2]);
        end
    endtask

    task automatic test_ignore_busy;
        int nv;
        nv = 0;
        launch(3'd0, 3'd4, 10, 2, 3'd5);
        for (int c = 1; c <= 10; c++) nv += ob_valid[c];
        for (int c = 2; c <= 6; c++) begin
            n_checks++;
            if (ob_data[c] !== 4'(2 * (c - 2) + 1)) begin
                n_fail++;
                $display("FAIL ignore_data c=%0d got=%0d want=%0d", c, ob_data[c], 2 * (c - 2) + 1);
            end
        end
        n_checks++;
        if (nv != 5 || ob_done[6] !== 1'b1 || ob_sum[6] !== 7'd25 || ob_max[6] !== 4'd9 || ob_busy[8] !== 1'b0 || ob_busy[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_final strobes=%0d done=%b sum=%0d max=%0d busy8=%b busy9=%b want 5,1,25,9,0,0", nv, ob_done[6], ob_sum[6], ob_max[6], ob_busy[8], ob_busy[9]);
        end
    endtask

    task automatic test_reset_mid;
        int nd;
        nd = 0;
        launch(3'd0, 3'd7, 4, 0, 3'd0);
        n_checks++;
        if (ob_valid[4] !== 1'b1 || ob_sum[4] !== 7'd9 || ob_busy[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before valid=%b sum=%0d busy=%b want 1,9,1", ob_valid[4], ob_sum[4], ob_busy[4]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ROM_addr, data_out, data_valid, sum, max_val, busy, done} !== 24'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear got=%h want=0", {ROM_addr, data_out, data_valid, sum, max_val, busy, done});
        end
        repeat (2) begin
            @(negedge clk);
            nd += done;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            nd += done + busy;
        end
        n_checks++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL mid_no_done activity=%0d want=0", nd);
        end
        launch(3'd1, 3'd1, 4, 0, 3'd0);
        n_checks++;
        if (ob_data[2] !== 4'd3 || ob_data[3] !== 4'd5 || ob_done[3] !== 1'b1 || ob_sum[3] !== 7'd8 || ob_max[3] !== 4'd5) begin
            n_fail++;
            $display("FAIL mid_fresh d2=%0d d3=%0d done=%b sum=%0d max=%0d want 3,5,1,8,5", ob_data[2], ob_data[3], ob_done[3], ob_sum[3], ob_max[3]);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_wrap();
        test_single();
        test_ignore_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
